// File: rtl/vslc_timer_bank_if.sv
// Configuration and start/stop bus of the VSLC timer bank, plus its timer pin outputs.
interface vslc_timer_bank_if #(
   parameter int NUM_CH = 4,
   parameter int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
);
   // No back-pressure anywhere: cfg_we is a single-cycle write strobe taken at every rising
   // edge where it is high, and en_set/en_clr are per-channel pulses sampled at each edge.
   logic                cfg_we;
   logic [CH_W-1:0]     cfg_ch;
   logic [2:0]          cfg_addr;
   logic [7:0]          cfg_wdata;
   logic [NUM_CH-1:0]   en_set;
   logic [NUM_CH-1:0]   en_clr;
   logic [NUM_CH-1:0]   tmr_out;
   logic [NUM_CH-1:0]   tmr_en;
   logic [NUM_CH-1:0]   tmr_done;
   logic [2*NUM_CH-1:0] dbg_state;

   modport master (
      output cfg_we, cfg_ch, cfg_addr, cfg_wdata, en_set, en_clr,
      input  tmr_out, tmr_en, tmr_done, dbg_state
   );

   modport slave (
      input  cfg_we, cfg_ch, cfg_addr, cfg_wdata, en_set, en_clr,
      output tmr_out, tmr_en, tmr_done, dbg_state
   );
endinterface

// File: rtl/vslc_timer_bank.sv
// NUM_CH independent two-phase timers with prescaler, cycle/one-shot/burst modes, polarity
// select and shadow/active configuration that only swaps at phase-B boundaries.
module vslc_timer_bank #(
   parameter int NUM_CH  = 4,
   parameter int CNT_W   = 16,
   parameter int DIV_W   = 4,
   parameter int BURST_W = 8,
   parameter int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input logic              clk,
   input logic              rst,
   vslc_timer_bank_if.slave bus
);
   localparam int PRE_W = (2 ** DIV_W) - 1;
   localparam int PER_W = (CNT_W > 16) ? CNT_W : 16;

   typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_A = 2'd1, ST_B = 2'd2} ch_state_e;

   logic [NUM_CH-1:0]   out_v, en_v, done_v;
   logic [2*NUM_CH-1:0] dbg_v;

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      logic [CNT_W-1:0]   sh_pa, sh_pb, ac_pa, ac_pb, cnt, cur_per;
      logic [CNT_W-1:0]   sh_pa_n, sh_pb_n, ac_pa_n, ac_pb_n, cnt_n;
      logic [PER_W-1:0]   ext_pa, ext_pb;
      logic [DIV_W-1:0]   sh_div, ac_div, sh_div_n, ac_div_n;
      logic [1:0]         sh_mode, ac_mode, sh_mode_n, ac_mode_n;
      logic               sh_pol, ac_pol, sh_pol_n, ac_pol_n;
      logic [BURST_W-1:0] sh_burst, sh_burst_n, left, left_n;
      logic [PRE_W-1:0]   presc, presc_n, mask;
      logic               out_q, out_n, done_q, done_n, wr, tick, load;
      ch_state_e          state, state_n;

      // Channel numbers outside 0..NUM_CH-1 match no instance and are dropped.
      assign wr = bus.cfg_we && (bus.cfg_ch == CH_W'(i));

      always_comb begin
         sh_div_n   = sh_div;
         sh_mode_n  = sh_mode;
         sh_pol_n   = sh_pol;
         sh_burst_n = sh_burst;
         ext_pa     = PER_W'(sh_pa);
         ext_pb     = PER_W'(sh_pb);
         if (wr) begin
            case (bus.cfg_addr)
               3'd0: ext_pa[7:0]  = bus.cfg_wdata;
               3'd1: ext_pa[15:8] = bus.cfg_wdata;
               3'd2: ext_pb[7:0]  = bus.cfg_wdata;
               3'd3: ext_pb[15:8] = bus.cfg_wdata;
               3'd4: begin
                  sh_div_n  = DIV_W'(bus.cfg_wdata[3:0]);
                  sh_mode_n = bus.cfg_wdata[5:4];
                  sh_pol_n  = bus.cfg_wdata[6];
               end
               3'd5: sh_burst_n = BURST_W'(bus.cfg_wdata);
               default: ;
            endcase
         end
         sh_pa_n = ext_pa[CNT_W-1:0];
         sh_pb_n = ext_pb[CNT_W-1:0];
      end

      assign mask    = ~({PRE_W{1'b1}} << ac_div);
      assign tick    = ((presc & mask) == mask);
      assign cur_per = (state == ST_B) ? ac_pb : ac_pa;

      always_comb begin
         state_n = state;
         cnt_n   = cnt;
         presc_n = presc;
         left_n  = left;
         out_n   = out_q;
         done_n  = 1'b0;
         load    = 1'b0;
         case (state)
            ST_IDLE: begin
               cnt_n   = '0;
               presc_n = '0;
               out_n   = sh_pol_n;
               if (bus.en_set[i]) begin
                  state_n = ST_A;
                  load    = 1'b1;
                  left_n  = (sh_burst == '0) ? BURST_W'(1) : sh_burst;
                  out_n   = ~sh_pol;
               end
            end
            default: begin
               presc_n = tick ? '0 : presc + PRE_W'(1);
               if (tick) begin
                  if (cnt != cur_per) begin
                     cnt_n = cnt + CNT_W'(1);
                  end else begin
                     cnt_n = '0;
                     if (state == ST_A) begin
                        state_n = ST_B;
                        out_n   = ac_pol;
                     end else if (ac_mode == 2'd1 || (ac_mode == 2'd2 && left == BURST_W'(1))) begin
                        state_n = ST_IDLE;
                        out_n   = ac_pol;
                        done_n  = 1'b1;
                        left_n  = '0;
                     end else begin
                        if (ac_mode == 2'd2) left_n = left - BURST_W'(1);
                        state_n = ST_A;
                        load    = 1'b1;
                        out_n   = ~sh_pol;
                     end
                  end
               end
            end
         endcase
         // A stop request overrides start, natural stop and its done pulse alike.
         if (bus.en_clr[i]) begin
            state_n = ST_IDLE;
            cnt_n   = '0;
            presc_n = '0;
            left_n  = '0;
            out_n   = sh_pol_n;
            done_n  = 1'b0;
            load    = 1'b0;
         end
         ac_pa_n   = load ? sh_pa   : ac_pa;
         ac_pb_n   = load ? sh_pb   : ac_pb;
         ac_div_n  = load ? sh_div  : ac_div;
         ac_mode_n = load ? sh_mode : ac_mode;
         ac_pol_n  = load ? sh_pol  : ac_pol;
      end

      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            state    <= ST_IDLE;
            sh_pa    <= CNT_W'(1);
            sh_pb    <= CNT_W'(2);
            sh_div   <= '0;
            sh_mode  <= '0;
            sh_pol   <= 1'b0;
            sh_burst <= BURST_W'(1);
            ac_pa    <= CNT_W'(1);
            ac_pb    <= CNT_W'(2);
            ac_div   <= '0;
            ac_mode  <= '0;
            ac_pol   <= 1'b0;
            cnt      <= '0;
            presc    <= '0;
            left     <= '0;
            out_q    <= 1'b0;
            done_q   <= 1'b0;
         end else begin
            state    <= state_n;
            sh_pa    <= sh_pa_n;
            sh_pb    <= sh_pb_n;
            sh_div   <= sh_div_n;
            sh_mode  <= sh_mode_n;
            sh_pol   <= sh_pol_n;
            sh_burst <= sh_burst_n;
            ac_pa    <= ac_pa_n;
            ac_pb    <= ac_pb_n;
            ac_div   <= ac_div_n;
            ac_mode  <= ac_mode_n;
            ac_pol   <= ac_pol_n;
            cnt      <= cnt_n;
            presc    <= presc_n;
            left     <= left_n;
            out_q    <= out_n;
            done_q   <= done_n;
         end
      end

      assign out_v[i]       = out_q;
      assign en_v[i]        = (state != ST_IDLE);
      assign done_v[i]      = done_q;
      assign dbg_v[2*i +: 2] = state;
   end

   assign bus.tmr_out   = out_v;
   assign bus.tmr_en    = en_v;
   assign bus.tmr_done  = done_v;
   assign bus.dbg_state = dbg_v;
endmodule

// File: tb/tb_vslc_timer_bank.sv
// Bench for vslc_timer_bank: expected pin waveforms come from phase lengths and run counts.
module tb_vslc_timer_bank;
   localparam int NC   = 4;
   localparam int CW   = 2;
   localparam int EW   = 3 * NC;
   localparam int MAXW = 128;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   vslc_timer_bank_if #(.NUM_CH(NC), .CH_W(CW)) bus ();

   vslc_timer_bank #(.NUM_CH(NC)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_tests = 0;
   int n_fail  = 0;
   string cur_tag = "init";
   logic [EW-1:0] exp_q[$];

   // bench's view of each channel's shadow configuration
   int m_pa[NC], m_pb[NC], m_div[NC], m_mode[NC], m_pol[NC], m_burst[NC];
   bit [MAXW-1:0] e_out[NC], e_en[NC], e_done[NC];

   task automatic check(input string name, input logic [EW-1:0] act, input logic [EW-1:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got done/en/out=%h, expected %h", name, act, exp);
      end
   endtask

   initial begin
      logic [EW-1:0] e;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check(cur_tag, {bus.tmr_done, bus.tmr_en, bus.tmr_out}, e);
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, required finish before 500000");
      $fatal(1, "watchdog");
   end

   task automatic reset_model();
      for (int c = 0; c < NC; c++) begin
         m_pa[c] = 1; m_pb[c] = 2; m_div[c] = 0; m_mode[c] = 0; m_pol[c] = 0; m_burst[c] = 1;
      end
   endtask

   // Expected per-cycle pins for cycles 1..w after a start pulse in cycle 0.
   task automatic build_ch(input int ch, input bit started, input int w);
      int t, la, lb, runs;
      for (int k = 0; k < w; k++) begin
         e_out[ch][k] = (m_pol[ch] != 0); e_en[ch][k] = 1'b0; e_done[ch][k] = 1'b0;
      end
      if (started) begin
         t  = 0;
         la = (m_pa[ch] + 1) << m_div[ch];
         lb = (m_pb[ch] + 1) << m_div[ch];
         if (m_mode[ch] == 1)      runs = 1;
         else if (m_mode[ch] == 2) runs = (m_burst[ch] == 0) ? 1 : m_burst[ch];
         else                      runs = w;
         for (int r = 0; r < runs && t < w; r++) begin
            for (int k = 0; k < la; k++) begin
               if (t < w) begin e_out[ch][t] = (m_pol[ch] == 0); e_en[ch][t] = 1'b1; end
               t++;
            end
            for (int k = 0; k < lb; k++) begin
               if (t < w) begin e_out[ch][t] = (m_pol[ch] != 0); e_en[ch][t] = 1'b1; end
               t++;
            end
         end
         if ((m_mode[ch] == 1 || m_mode[ch] == 2) && t < w) e_done[ch][t] = 1'b1;
      end
   endtask

   task automatic push_window(input int w);
      logic [EW-1:0] v;
      for (int k = 0; k < w; k++) begin
         v = '0;
         for (int c = 0; c < NC; c++) begin
            v[c] = e_out[c][k]; v[NC+c] = e_en[c][k]; v[2*NC+c] = e_done[c][k];
         end
         exp_q.push_back(v);
      end
   endtask

   task automatic drain(input int budget);
      int g = 0;
      do begin
         @(posedge clk);
         g++;
      end while (exp_q.size() != 0 && g < budget);
      #1;
      if (exp_q.size() != 0) begin
         n_tests++; n_fail++;
         $display("FAIL drain_%s: %0d entries left, required 0", cur_tag, exp_q.size());
         exp_q.delete();
      end
   endtask

   // All tasks below start and end 1 time unit after a rising edge.
   task automatic wr(input int ch, input int addr, input int data);
      bus.cfg_we = 1'b1; bus.cfg_ch = CW'(ch); bus.cfg_addr = 3'(addr); bus.cfg_wdata = 8'(data);
      @(posedge clk); #1;
      bus.cfg_we = 1'b0;
      case (addr)
         0: m_pa[ch] = (m_pa[ch] & 'hFF00) | (data & 'hFF);
         1: m_pa[ch] = (m_pa[ch] & 'hFF) | ((data & 'hFF) << 8);
         2: m_pb[ch] = (m_pb[ch] & 'hFF00) | (data & 'hFF);
         3: m_pb[ch] = (m_pb[ch] & 'hFF) | ((data & 'hFF) << 8);
         4: begin m_div[ch] = data & 15; m_mode[ch] = (data >> 4) & 3; m_pol[ch] = (data >> 6) & 1; end
         5: m_burst[ch] = data & 'hFF;
         default: ;
      endcase
   endtask

   task automatic cfg_chan(input int ch, input int pa, input int pb, input int ctrl, input int burst);
      wr(ch, 0, pa & 'hFF); wr(ch, 1, pa >> 8);
      wr(ch, 2, pb & 'hFF); wr(ch, 3, pb >> 8);
      wr(ch, 4, ctrl); wr(ch, 5, burst);
   endtask

   task automatic start(input logic [NC-1:0] set_m, input logic [NC-1:0] clr_m, input int w);
      bus.en_set = set_m; bus.en_clr = clr_m;
      @(posedge clk); #1;
      bus.en_set = '0; bus.en_clr = '0;
      for (int c = 0; c < NC; c++) build_ch(c, set_m[c] && !clr_m[c], w);
   endtask

   task automatic do_clr();
      bus.en_clr = '1;
      @(posedge clk); #1;
      bus.en_clr = '0;
      for (int c = 0; c < NC; c++) build_ch(c, 1'b0, 1);
      push_window(1);
      drain(4);
   endtask

   initial begin
      logic [NC-1:0] mask;
      int t;
      rst = 1'b1;
      bus.cfg_we = 1'b0; bus.cfg_ch = '0; bus.cfg_addr = '0; bus.cfg_wdata = '0;
      bus.en_set = '0; bus.en_clr = '0;
      reset_model();
      #3;
      check("reset_initial", {bus.tmr_done, bus.tmr_en, bus.tmr_out}, '0);
      @(posedge clk); #1;
      rst = 1'b0;

      // Reset asserted while ch0 is in its high phase, between clock edges.
      cur_tag = "reset_run";
      start(4'b0001, 4'b0000, 1); push_window(1); drain(4);
      #2; rst = 1'b1; #1;
      check("reset_async", {bus.tmr_done, bus.tmr_en, bus.tmr_out}, '0);
      @(posedge clk); #1;
      rst = 1'b0;
      reset_model();
      cur_tag = "reset_idle";
      for (int c = 0; c < NC; c++) build_ch(c, 1'b0, 4);
      push_window(4); drain(8);

      cur_tag = "cycle_wave";
      cfg_chan(0, 2, 1, 8'h00, 1);
      start(4'b0001, 4'b0000, 16); push_window(16); drain(20);
      do_clr();

      cur_tag = "oneshot_div";
      cfg_chan(1, 0, 0, 8'h11, 1);
      start(4'b0010, 4'b0000, 8); push_window(8); drain(12);
      do_clr();

      cur_tag = "burst3";
      cfg_chan(2, 0, 0, 8'h20, 3);
      start(4'b0100, 4'b0000, 10); push_window(10); drain(14);
      cur_tag = "burst0";
      wr(2, 5, 0);
      start(4'b0100, 4'b0000, 6); push_window(6); drain(10);
      do_clr();

      // period_a rewritten in the first high phase: takes effect after the first B phase.
      cur_tag = "shadow_update";
      cfg_chan(0, 2, 1, 8'h00, 1);
      start(4'b0001, 4'b0000, 20);
      for (int k = 0; k < 20; k++) begin
         t = k + 1;
         e_out[0][k] = (t <= 3) || (t >= 6 && t <= 11) || (t >= 14 && t <= 19);
      end
      push_window(20);
      wr(0, 0, 5);
      drain(30);
      do_clr();

      cur_tag = "set_clr_same";
      start(4'b1000, 4'b1000, 5); push_window(5); drain(9);

      cur_tag = "idle_pol";
      wr(3, 4, 8'h40);
      for (int c = 0; c < NC; c++) build_ch(c, 1'b0, 3);
      push_window(3); drain(7);
      wr(3, 4, 8'h00);

      for (int s = 0; s < 6; s++) begin
         for (int c = 0; c < NC; c++) begin
            cfg_chan(c, $urandom_range(0, 4), $urandom_range(0, 4),
                     ($urandom_range(0, 1) << 7) | ($urandom_range(0, 1) << 6) |
                     ($urandom_range(0, 3) << 4) | $urandom_range(0, 2),
                     $urandom_range(0, 3));
            if ($urandom_range(0, 1) == 1) wr(c, $urandom_range(6, 7), $urandom_range(0, 255));
         end
         mask = NC'($urandom_range(1, 15));
         cur_tag = $sformatf("rand%0d", s);
         start(mask, 4'b0000, 70); push_window(70); drain(80);
         do_clr();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
